// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, captures {pc, instr} from instruction memory into a
// small FIFO and hands entries to decode over valid/ready; redirects reload and flush.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        imem_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   buf_pc_q    [FIFO_DEPTH];
    logic [31:0]   buf_instr_q [FIFO_DEPTH];
    logic          push;
    logic          pop;
    logic          redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign imem_pc   = pc_q;
    assign out_valid = (cnt_q != '0);
    assign out_pc    = buf_pc_q[rd_q];
    assign out_instr = buf_instr_q[rd_q];
    assign pop       = out_valid & out_ready;
    assign push      = imem_valid & ~redirect_valid & ((cnt_q < CW'(FIFO_DEPTH)) | pop);

    always_comb begin
        pc_d  = pc_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (redirect_valid) begin
            // Flush: a same-cycle pop is still taken; the incoming imem word is dropped.
            pc_d  = {redirect_pc[31:2], 2'b00};
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                pc_d = pc_q + 32'd4;
                wr_d = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_q]    <= pc_q;
            buf_instr_q[wr_q] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: 1-cycle-latency memory model plus an
// expected-stream scoreboard compared on every consumer handshake.
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        imem_valid;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] lat_addr;
    logic        lat_vld;

    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_pc(imem_pc), .imem_instr(imem_instr), .imem_valid(imem_valid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 18) | 32'h13 | ((a != 32'd0) ? 32'h80 : 32'h0);
    endfunction

    // Memory: latches the address each cycle, valid once latched address == pc
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_vld  <= 1'b0;
            lat_addr <= '0;
        end else begin
            lat_vld  <= 1'b1;
            lat_addr <= imem_pc;
        end
    end
    assign imem_instr = mem_word(lat_addr);
    assign imem_valid = lat_vld && (lat_addr == imem_pc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_stream(input logic [31:0] base);
        logic [31:0] a;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            a = base + 32'(4 * i);
            exp_q.push_back({a, mem_word(a)});
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e[63:32]);
                check("out_instr", out_instr, e[31:0]);
            end
            pops++;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        redirect_valid = 1'b0;
        expect_stream(RST_PC);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imem_pc", imem_pc, RST_PC);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int target;
        int cyc;
        target = pops + n;
        cyc = 0;
        while (pops < target && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        check(tag, 32'(pops >= target), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = tgt;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        expect_stream({tgt[31:2], 2'b00});
    endtask

    initial begin
        int n;
        int p0;
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int p0;
        // 1: streaming at full rate, one valid every other cycle
        out_ready = 1'b1;
        do_reset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("t1_first_valid", 32'(out_valid), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("t1_cadence", 32'(out_valid), 32'((i % 2) == 0));
        end
        wait_pops("t1_pops", 2, 20);

        // 2: consumer stalled, FIFO saturates, then drains in order
        out_ready = 1'b0;
        do_reset();
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_imem_pc_hold", imem_pc, 32'h8);
        check("t2_head_pc", out_pc, 32'h0);
        check("t2_head_instr", out_instr, mem_word(32'h0));
        check("t2_imem_valid_hold", 32'(imem_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_pops("t2_drain", 3, 20);

        // 3: redirect while FIFO holds pc 0,4
        out_ready = 1'b0;
        do_reset();
        repeat (6) @(posedge clk);
        redirect(32'h100);
        @(negedge clk);
        check("t3_out_valid", 32'(out_valid), 32'd0);
        check("t3_imem_pc", imem_pc, 32'h100);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_pops("t3_pops", 2, 20);

        // 4: misaligned redirect target
        redirect(32'h203);
        @(negedge clk);
        check("t4_imem_pc", imem_pc, 32'h200);
        check("t4_out_valid", 32'(out_valid), 32'd0);
        wait_pops("t4_pops", 2, 20);

        // 5: redirect with full FIFO, imem valid and a pop in the same cycle
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t5_pre_full", 32'(out_valid), 32'd1);
        check("t5_pre_imem_valid", 32'(imem_valid), 32'd1);
        p0 = pops;
        @(posedge clk);
        #1 out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        expect_stream(32'h300);
        @(negedge clk);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_pop_once", 32'(pops), 32'(p0 + 1));
        check("t5_imem_pc", imem_pc, 32'h300);
        wait_pops("t5_pops", 2, 20);

        // 6: asynchronous reset with FIFO full
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        expect_stream(RST_PC);
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_pc", imem_pc, RST_PC);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        wait_pops("t6_restart", 3, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
